// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, initial hash values, FSM states and the
// bit-mixing functions used by the round and message-schedule logic.
package sha256_pkg;

  typedef logic [31:0] word_t;

  // Working variables a..h; field a occupies the most significant word.
  typedef struct packed {
    word_t a, b, c, d, e, f, g, h;
  } work_t;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, OUT} state_t;

  localparam logic [255:0] IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [255:0] IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t big_s0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_s1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_s0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_s1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic logic [255:0] iv_sel(input logic sha224);
    return sha224 ? IV224 : IV256;
  endfunction

  // Eight independent 32-bit lane additions, used for the chaining-value update.
  function automatic logic [255:0] add_lanes(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: working variables, round constant and
// schedule word in, updated working variables out.
module sha256_round
  import sha256_pkg::*;
(
  input  work_t i_state,
  input  word_t i_k,
  input  word_t i_w,
  output work_t o_state
);

  word_t w_t1, w_t2;

  assign w_t1 = i_state.h + big_s1(i_state.e) + ch(i_state.e, i_state.f, i_state.g) + i_k + i_w;
  assign w_t2 = big_s0(i_state.a) + maj(i_state.a, i_state.b, i_state.c);

  always_comb begin
    o_state.a = w_t1 + w_t2;
    o_state.b = i_state.a;
    o_state.c = i_state.b;
    o_state.d = i_state.c;
    o_state.e = i_state.d + w_t1;
    o_state.f = i_state.e;
    o_state.g = i_state.f;
    o_state.h = i_state.g;
  end

endmodule

// File: rtl/sha256_stream_core.sv
// Block-streaming SHA-256 core, UNROLL (1, 2 or 4) rounds per clock.
// Define SHA224_MODE_EN to add the mode_224 port selecting SHA-224 per message.
module sha256_stream_core
  import sha256_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [255:0] dig_data,
`ifdef SHA224_MODE_EN
  input  logic         mode_224,
`endif
  output logic         busy
);

  localparam logic [5:0] STEP     = 6'(UNROLL);
  localparam logic [5:0] LAST_RND = 6'(64 - UNROLL);

  state_t       r_state, w_state_next;
  logic [255:0] r_h;
  work_t        r_work, w_work_next;
  word_t        r_win [16];
  word_t        w_win_next [16];
  logic [5:0]   r_rnd;
  logic         r_last;
  logic         w_accept;
  logic [255:0] w_iv, w_dig;

  assign w_accept = blk_valid && (r_state == IDLE);

`ifdef SHA224_MODE_EN
  logic r_mode224;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_mode224 <= 1'b0;
    else if (w_accept && blk_first)  r_mode224 <= mode_224;
  end

  assign w_iv  = iv_sel(mode_224);
  assign w_dig = r_mode224 ? {r_h[255:32], 32'h0} : r_h;
`else
  assign w_iv  = iv_sel(1'b0);
  assign w_dig = r_h;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns w_state_next and no latch is inferred.
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (blk_valid)            w_state_next = ROUND;
      ROUND:   if (r_rnd == LAST_RND)    w_state_next = FINAL;
      FINAL:   w_state_next = r_last ? OUT : IDLE;
      OUT:     if (dig_ready)            w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    blk_ready = (r_state == IDLE);
    busy      = (r_state != IDLE);
    dig_valid = (r_state == OUT);
    dig_data  = dig_valid ? w_dig : '0;
  end

  // Rolling schedule window: extend by UNROLL words, then slide forward by the same amount.
  always_comb begin
    word_t ext [16+UNROLL];
    for (int i = 0; i < 16; i++) ext[i] = r_win[i];
    for (int j = 0; j < UNROLL; j++)
      ext[16+j] = small_s1(ext[14+j]) + ext[9+j] + small_s0(ext[1+j]) + ext[j];
    for (int i = 0; i < 16; i++) w_win_next[i] = ext[i+UNROLL];
  end

  for (genvar i = 0; i < UNROLL; i++) begin : g_round
    work_t w_in, w_out;
    if (i == 0) begin : g_head
      assign w_in = r_work;
    end else begin : g_link
      assign w_in = g_round[i-1].w_out;
    end
    sha256_round u_round (
      .i_state (w_in),
      .i_k     (K[r_rnd + 6'(i)]),
      .i_w     (r_win[i]),
      .o_state (w_out)
    );
  end

  assign w_work_next = g_round[UNROLL-1].w_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h    <= IV256;
      r_work <= '0;
      r_rnd  <= '0;
      r_last <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (w_accept) begin
          r_work <= blk_first ? w_iv : r_h;
          if (blk_first) r_h <= w_iv;
          r_rnd  <= '0;
          r_last <= blk_last;
        end
        ROUND: begin
          r_work <= w_work_next;
          r_rnd  <= r_rnd + STEP;
        end
        FINAL:   r_h <= add_lanes(r_h, r_work);
        default: ;
      endcase
    end
  end

  // NOTE: the window is pure datapath, always loaded before use, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < 16; i++) r_win[i] <= blk_data[511-32*i -: 32];
    end else if (r_state == ROUND) begin
      for (int i = 0; i < 16; i++) r_win[i] <= w_win_next[i];
    end
  end

endmodule

// File: tb/tb_sha256_stream_core.sv
// Scoreboard bench: DUT 0 runs UNROLL=1, DUT 1 runs UNROLL=4; directed FIPS 180-4 vectors.
// Define SHA224_MODE_EN to add the SHA-224 vector.
module tb_sha256_stream_core;

  localparam logic [255:0] DIG_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_TWO = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] DIG_224 = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;

  localparam logic [511:0] BLK_ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] BLK_TWO_A = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_TWO_B = {{15{32'h0}}, 32'h000001c0};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   blk_valid = '0;
  logic [1:0]   dig_ready = '1;
  logic [1:0]   blk_ready, dig_valid, busy;
  logic [511:0] blk_data = '0;
  logic         blk_first = 1'b0;
  logic         blk_last = 1'b0;
  logic [255:0] dig_data0, dig_data1;
`ifdef SHA224_MODE_EN
  logic         mode_224 = 1'b0;
`endif

  typedef struct {
    logic [255:0] dig;
    int           due;
  } exp_t;

  exp_t       q0[$], q1[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         edge_cnt = 0;
  logic [1:0] prev_v = '0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  sha256_stream_core #(.UNROLL(1)) u_dut0 (
    .clk(clk), .rst(rst), .blk_valid(blk_valid[0]), .blk_ready(blk_ready[0]),
    .blk_data(blk_data), .blk_first(blk_first), .blk_last(blk_last),
    .dig_valid(dig_valid[0]), .dig_ready(dig_ready[0]), .dig_data(dig_data0),
`ifdef SHA224_MODE_EN
    .mode_224(mode_224),
`endif
    .busy(busy[0]));

  sha256_stream_core #(.UNROLL(4)) u_dut1 (
    .clk(clk), .rst(rst), .blk_valid(blk_valid[1]), .blk_ready(blk_ready[1]),
    .blk_data(blk_data), .blk_first(blk_first), .blk_last(blk_last),
    .dig_valid(dig_valid[1]), .dig_ready(dig_ready[1]), .dig_data(dig_data1),
`ifdef SHA224_MODE_EN
    .mode_224(mode_224),
`endif
    .busy(busy[1]));

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Cycle T (handshake) ends at edge hs, so cycle T+64/U+2 begins at edge hs+64/U+1.
  function automatic int lat(input int d);
    return (d == 0) ? 65 : 17;
  endfunction

  // Called just after a negedge; returns just after the negedge following the handshake.
  task automatic send(input int d, input logic [511:0] data, input logic first, input logic last,
                      input logic push, input logic [255:0] dig);
    int   guard;
    exp_t e;
    blk_data     = data;
    blk_first    = first;
    blk_last     = last;
    blk_valid[d] = 1'b1;
    guard        = 0;
    while (!blk_ready[d] && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("send handshake in budget", 256'(guard < 300), 256'(1));
    @(negedge clk);
    blk_valid[d] = 1'b0;
    if (push) begin
      e.dig = dig;
      e.due = edge_cnt + lat(d);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic wait_idle(input int d);
    int guard;
    guard = 0;
    while (((d == 0) ? q0.size() : q1.size()) != 0 || dig_valid[d] || !blk_ready[d]) begin
      if (guard >= 300) break;
      @(negedge clk);
      guard++;
    end
    check("return to idle in budget", 256'(guard < 300), 256'(1));
  endtask

  // Monitor: pops the scoreboard on each new digest; digest bus must be zero otherwise.
  always @(negedge clk) begin
    logic         v;
    logic [255:0] dd;
    exp_t         e;
    for (int d = 0; d < 2; d++) begin
      v  = dig_valid[d];
      dd = (d == 0) ? dig_data0 : dig_data1;
      if (!v) begin
        check("dig_data zero while idle", dd, '0);
      end else if (!prev_v[d]) begin
        if (((d == 0) ? q0.size() : q1.size()) == 0) begin
          check("unexpected digest", dd, '0);
        end else begin
          if (d == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          check("digest value", dd, e.dig);
          check("digest latency", 256'(edge_cnt), 256'(e.due));
        end
      end
      prev_v[d] = v;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset blk_ready", 256'(blk_ready), 256'(2'b11));
    check("reset busy", 256'(busy), 256'(2'b00));
    check("reset dig_valid", 256'(dig_valid), 256'(2'b00));

    // Single-block "abc", then the two-block message, on UNROLL=1.
    send(0, BLK_ABC, 1'b1, 1'b1, 1'b1, DIG_ABC);
    wait_idle(0);
    send(0, BLK_TWO_A, 1'b1, 1'b0, 1'b0, '0);
    send(0, BLK_TWO_B, 1'b0, 1'b1, 1'b1, DIG_TWO);
    wait_idle(0);

    // Consumer back-pressure: digest must hold steady and no block may be accepted.
    dig_ready[0] = 1'b0;
    send(0, BLK_ABC, 1'b1, 1'b1, 1'b1, DIG_ABC);
    for (int i = 0; i < 100 && !dig_valid[0]; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("stall dig_valid", 256'(dig_valid[0]), 256'(1));
      check("stall dig_data", dig_data0, DIG_ABC);
      check("stall blk_ready", 256'(blk_ready[0]), 256'(0));
      check("stall busy", 256'(busy[0]), 256'(1));
      @(negedge clk);
    end
    dig_ready[0] = 1'b1;
    wait_idle(0);
    send(0, BLK_ABC, 1'b1, 1'b1, 1'b1, DIG_ABC);
    wait_idle(0);

    // Reset mid-ROUND discards the block; a non-first block afterwards chains from IV.
    send(0, BLK_TWO_A, 1'b1, 1'b1, 1'b0, '0);
    repeat (30) @(negedge clk);
    check("mid-round busy", 256'(busy[0]), 256'(1));
    rst = 1'b1;
    #1;
    check("async reset blk_ready", 256'(blk_ready[0]), 256'(1));
    check("async reset busy", 256'(busy[0]), 256'(0));
    check("async reset dig_valid", 256'(dig_valid[0]), 256'(0));
    check("async reset dig_data", dig_data0, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(0, BLK_ABC, 1'b0, 1'b1, 1'b1, DIG_ABC);
    wait_idle(0);

    // UNROLL=4 instance.
    send(1, BLK_ABC, 1'b1, 1'b1, 1'b1, DIG_ABC);
    wait_idle(1);
    send(1, BLK_TWO_A, 1'b1, 1'b0, 1'b0, '0);
    send(1, BLK_TWO_B, 1'b0, 1'b1, 1'b1, DIG_TWO);
    wait_idle(1);

`ifdef SHA224_MODE_EN
    mode_224 = 1'b1;
    send(0, BLK_ABC, 1'b1, 1'b1, 1'b1, DIG_224);
    wait_idle(0);
    mode_224 = 1'b0;
    send(0, BLK_ABC, 1'b1, 1'b1, 1'b1, DIG_ABC);
    wait_idle(0);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard 0 drained", 256'(q0.size()), 256'(0));
    check("scoreboard 1 drained", 256'(q1.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sha256_stream_core.md
SHA256_STREAM_CORE -- requirements
Module: sha256_stream_core

Interface
REQ-001 SHALL have parameter UNROLL, default 1, rounds computed per clock; legal values 1, 2, 4.
REQ-002 SHALL have port clk  input  1  clock, all state on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port blk_valid  input  1  512-bit block offered.
REQ-005 SHALL have port blk_ready  output  1  core accepts block this cycle.
REQ-006 SHALL have port blk_data  input  512  padded block, word 0 in bits [511:480].
REQ-007 SHALL have port blk_first  input  1  block starts a message; chaining value reloads to IV.
REQ-008 SHALL have port blk_last  input  1  block ends a message; digest is emitted.
REQ-009 SHALL have port dig_valid  output  1  digest available.
REQ-010 SHALL have port dig_ready  input  1  consumer takes digest.
REQ-011 SHALL have port dig_data  output  256  digest, H0 in bits [255:224].
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, ROUND, FINAL, OUT.
REQ-014 IDLE: blk_ready=1; blk_valid&blk_ready (cycle T) SHALL latch blk_data, load a..h from chaining H (or IV if blk_first), round counter=0, go ROUND.
REQ-015 ROUND SHALL execute UNROLL rounds per cycle for 64/UNROLL cycles (T+1..T+64/UNROLL), then go FINAL.
REQ-016 Message schedule SHALL use a 16-word rolling window; W[t]=s1(W[t-2])+W[t-7]+s0(W[t-15])+W[t-16] for t>=16.
REQ-017 All additions SHALL be modulo 2^32; rotates per FIPS 180-4 (S0: 2,13,22; S1: 6,11,25; s0: 7,18,>>3; s1: 17,19,>>10).
REQ-018 FINAL (one cycle) SHALL set H_i <= H_i + a..h; go OUT if block was last, else IDLE.
REQ-019 OUT: dig_valid=1, dig_data=H stable, blk_ready=0; on dig_ready go IDLE in the following cycle.
REQ-020 dig_valid SHALL first assert at cycle T+64/UNROLL+2 after the accepting handshake of a last block.
REQ-021 blk_first&blk_last together SHALL be a single-block message.
REQ-022 A non-first block SHALL chain from the previous H; a non-first block after reset SHALL chain from IV.
REQ-023 blk_ready SHALL be 0 outside IDLE; inputs other than dig_ready are ignored outside IDLE.
REQ-024 dig_data SHALL be 0 whenever dig_valid=0.

Reset
REQ-025 rst SHALL force IDLE, H=IV, counter=0, blk_ready=1, dig_valid=0, dig_data=0, busy=0, from any state including mid-ROUND; the in-flight block is discarded.

Configuration
REQ-026 Macro SHA224_MODE_EN defined: SHALL add port mode_224 (input, 1), sampled on a blk_first handshake; when 1, IV = SHA-224 IV and dig_data = {H0..H6, 32'h0}.
REQ-027 Macro SHA224_MODE_EN undefined: SHALL have no mode_224 port; SHA-256 only.

Structure
REQ-028 Package sha256_pkg SHALL hold the K[0:63] table, the SHA-256/224 IV constants, the FSM state enum and the sigma/Sigma/ch/maj functions.
REQ-029 Sub-module sha256_round (combinational single round: a..h, K, W in -> a..h out) SHALL be instantiated UNROLL times in a chain.

Verification
REQ-030 "abc" single block, UNROLL=1 -> dig_data=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; dig_valid at T+66.
REQ-031 56-char "abcdbcdecdefdefg...nopq" two blocks -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; no dig_valid after block 1.
REQ-032 UNROLL=4, "abc" -> same digest as REQ-030 with dig_valid at T+18.
REQ-033 dig_ready held 0 for 10 cycles -> dig_data stable, blk_ready=0; the next "abc" message hashes correctly after release.
REQ-034 rst pulsed at round 30, then "abc" -> all outputs 0 during reset; correct "abc" digest afterwards.
REQ-035 SHA224_MODE_EN, mode_224=1, "abc" -> dig_data=23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.
